// File: rtl/mmio_peripheral.sv
// mmio_peripheral: 16-byte MMIO register window on the data-memory bus.
// Holds the PWM duty register (LED/RGB) and free-running microsecond and
// millisecond counters. Loads are registered with one cycle of latency.
module mmio_peripheral #(
   parameter logic [31:0] BASE_ADDR   = 32'hFFFF_FFF0,
   parameter int unsigned CLK_FREQ_HZ = 12_000_000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  funct3,
   input  logic        dmem_wren,
   input  logic [31:0] dmem_address,
   input  logic [31:0] dmem_data_in,
   output logic [31:0] dmem_data_out,
   output logic        hit,
   output logic        led,
   output logic        red,
   output logic        green,
   output logic        blue
);

   localparam int unsigned US_DIV = CLK_FREQ_HZ / 1_000_000;
   localparam int unsigned US_W   = $clog2(US_DIV);
   localparam int unsigned MS_W   = 10;
   localparam int unsigned MS_DIV = 1000;

   localparam logic [1:0] OFF_DUTY   = 2'd0;
   localparam logic [1:0] OFF_MICROS = 2'd1;
   localparam logic [1:0] OFF_MILLIS = 2'd2;

   // Bus decode
   logic        w_in_win;
   logic [1:0]  w_off;
   logic [1:0]  w_lane;
   logic [3:0]  w_be;
   logic [31:0] w_wdata;
   logic [31:0] w_rword;
   logic [15:0] w_shift;
   logic [31:0] w_rdata;

   // Timebase
   logic            w_us_tick;
   logic            w_ms_wrap;
   logic [US_W-1:0] r_us_pre;
   logic [MS_W-1:0] r_ms_pre;
   logic [31:0]     r_micros;
   logic [31:0]     r_millis;

   // Registers and PWM
   logic [31:0] r_duty;
   logic [31:0] r_shadow;
   logic [7:0]  r_pwm_cnt;
   logic [3:0]  r_pwm;
   logic [7:0]  w_cnt_nxt;
   logic [31:0] w_shadow_nxt;
   logic [3:0]  w_pwm_nxt;
   logic [31:0] r_data_out;
   logic        r_hit;

   assign w_in_win = (dmem_address[31:4] == BASE_ADDR[31:4]);
   assign w_off    = dmem_address[3:2];
   assign w_lane   = dmem_address[1:0];

   // Store byte enables and lane-replicated store data; only aligned sb/sh/sw to DUTY commit
   always_comb begin
      w_be    = 4'b0000;
      w_wdata = dmem_data_in;
      case (funct3)
         3'b000: begin
            w_be    = 4'b0001 << w_lane;
            w_wdata = {4{dmem_data_in[7:0]}};
         end
         3'b001: begin
            if (!w_lane[0]) w_be = w_lane[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{dmem_data_in[15:0]}};
         end
         3'b010: begin
            if (w_lane == 2'b00) w_be = 4'b1111;
         end
         default: w_be = 4'b0000;
      endcase
      if (!(dmem_wren && w_in_win && (w_off == OFF_DUTY))) w_be = 4'b0000;
   end

   // Load path: select register, shift addressed lane(s) down, extend, zero on misalignment
   always_comb begin
      case (w_off)
         OFF_DUTY:   w_rword = r_duty;
         OFF_MICROS: w_rword = r_micros;
         OFF_MILLIS: w_rword = r_millis;
         default:    w_rword = 32'd0;
      endcase
      w_shift = 16'(w_rword >> {w_lane, 3'b000});
      w_rdata = 32'd0;
      case (funct3[1:0])
         2'b00: w_rdata = funct3[2] ? {24'd0, w_shift[7:0]}
                                    : {{24{w_shift[7]}}, w_shift[7:0]};
         2'b01: begin
            if (!w_lane[0])
               w_rdata = funct3[2] ? {16'd0, w_shift[15:0]}
                                   : {{16{w_shift[15]}}, w_shift[15:0]};
         end
         default: begin
            if (w_lane == 2'b00) w_rdata = w_rword;
         end
      endcase
   end

   // Bus-side registers: DUTY lanes, registered load data and hit flag
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_duty     <= 32'd0;
         r_data_out <= 32'd0;
         r_hit      <= 1'b0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (w_be[i]) r_duty[8*i +: 8] <= w_wdata[8*i +: 8];
         end
         r_data_out <= w_in_win ? w_rdata : 32'd0;
         r_hit      <= w_in_win;
      end
   end

   assign w_us_tick = (r_us_pre == US_W'(US_DIV - 1));
   assign w_ms_wrap = w_us_tick && (r_ms_pre == MS_W'(MS_DIV - 1));

   // Microsecond prescaler and counter, millisecond prescaler and counter
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_us_pre <= '0;
         r_ms_pre <= '0;
         r_micros <= 32'd0;
         r_millis <= 32'd0;
      end else begin
         r_us_pre <= w_us_tick ? US_W'(0) : r_us_pre + US_W'(1);
         if (w_us_tick) begin
            r_micros <= r_micros + 32'd1;
            r_ms_pre <= w_ms_wrap ? MS_W'(0) : r_ms_pre + MS_W'(1);
         end
         if (w_ms_wrap) r_millis <= r_millis + 32'd1;
      end
   end

   // Next PWM state: shadows reload at the period boundary so outputs equal cnt < shadow
   always_comb begin
      w_cnt_nxt    = r_pwm_cnt + 8'd1;
      w_shadow_nxt = (r_pwm_cnt == 8'hFF) ? r_duty : r_shadow;
      for (int i = 0; i < 4; i++) begin
         w_pwm_nxt[i] = (w_cnt_nxt < w_shadow_nxt[8*i +: 8]);
      end
   end

   // PWM counter, shadow duties and registered channel outputs
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_pwm_cnt <= 8'd0;
         r_shadow  <= 32'd0;
         r_pwm     <= 4'd0;
      end else begin
         r_pwm_cnt <= w_cnt_nxt;
         r_shadow  <= w_shadow_nxt;
         r_pwm     <= w_pwm_nxt;
      end
   end

   assign dmem_data_out = r_data_out;
   assign hit           = r_hit;
   assign led           = r_pwm[0];
   assign red           = r_pwm[1];
   assign green         = r_pwm[2];
   assign blue          = r_pwm[3];

endmodule

// File: tb/tb_mmio_peripheral.sv
// tb_mmio_peripheral: directed bench for the MMIO peripheral at 12 MHz.
module tb_mmio_peripheral;

   localparam int unsigned US_DIV = 12;
   localparam logic [31:0] A_DUTY = 32'hFFFF_FFF0;
   localparam logic [31:0] A_US   = 32'hFFFF_FFF4;
   localparam logic [31:0] A_MS   = 32'hFFFF_FFF8;
   localparam logic [2:0]  F_B    = 3'b000;
   localparam logic [2:0]  F_H    = 3'b001;
   localparam logic [2:0]  F_W    = 3'b010;
   localparam logic [2:0]  F_BU   = 3'b100;
   localparam logic [2:0]  F_HU   = 3'b101;

   logic        clk;
   logic        reset;
   logic [2:0]  funct3;
   logic        dmem_wren;
   logic [31:0] dmem_address;
   logic [31:0] dmem_data_in;
   logic [31:0] dmem_data_out;
   logic        hit;
   logic        led;
   logic        red;
   logic        green;
   logic        blue;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct packed {
      logic        wren;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_data;
      logic        exp_hit;
      logic        use_us;
   } vec_t;

   vec_t vecs[$];

   mmio_peripheral #(
      .BASE_ADDR   (32'hFFFF_FFF0),
      .CLK_FREQ_HZ (12_000_000)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .funct3        (funct3),
      .dmem_wren     (dmem_wren),
      .dmem_address  (dmem_address),
      .dmem_data_in  (dmem_data_in),
      .dmem_data_out (dmem_data_out),
      .hit           (hit),
      .led           (led),
      .red           (red),
      .green         (green),
      .blue          (blue)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #3_000_000;
      $display("FAIL watchdog timeout at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   function automatic vec_t mk(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] wd, input logic [31:0] ed,
                               input logic eh, input logic us);
      return {wr, f3, a, wd, ed, eh, us};
   endfunction

   // MICROS value sampled at request edge number cyc (edges counted from reset release)
   function automatic logic [31:0] us_model();
      return 32'((cyc - 1) / int'(US_DIV));
   endfunction

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   task automatic drive(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d);
      dmem_wren    = wr;
      funct3       = f3;
      dmem_address = a;
      dmem_data_in = d;
   endtask

   // Step until pwm_cnt equals target, optionally requiring constant outputs on the way
   task automatic wait_cnt(input int target, input logic [3:0] exp_out, input bit chk_en,
                           input string name);
      int bad = 0;
      while ((cyc % 256) != target) begin
         step();
         if ({blue, green, red, led} !== exp_out) bad++;
      end
      if (chk_en) chk32(name, 32'(bad), 32'd0);
   endtask

   // One full PWM period from pwm_cnt==255: shape and high count per channel
   task automatic run_period(input string name, input logic [31:0] duty);
      int bad;
      int hi[4];
      logic [3:0] act;
      logic [3:0] expv;
      bad = 0;
      for (int c = 0; c < 4; c++) hi[c] = 0;
      for (int n = 0; n < 256; n++) begin
         step();
         act = {blue, green, red, led};
         for (int c = 0; c < 4; c++) begin
            expv[c] = (8'(cyc % 256) < duty[8*c +: 8]);
            if (act[c]) hi[c]++;
         end
         if (act !== expv) bad++;
      end
      chk32($sformatf("%s shape", name), 32'(bad), 32'd0);
      for (int c = 0; c < 4; c++)
         chk32($sformatf("%s ch%0d highs", name, c), 32'(hi[c]), 32'(duty[8*c +: 8]));
   endtask

   initial begin
      int bad_out;
      int bad_us;

      // Table: {wren, funct3, addr, wdata, expected data, expected hit, expect MICROS model}
      vecs.push_back(mk(1, F_W,  A_DUTY,          32'h80FF_4010, 32'h0000_0000, 1, 0));
      vecs.push_back(mk(0, F_B,  32'hFFFF_FFF1,   32'h0,         32'h0000_0040, 1, 0));
      vecs.push_back(mk(0, F_B,  32'hFFFF_FFF3,   32'h0,         32'hFFFF_FF80, 1, 0));
      vecs.push_back(mk(0, F_BU, 32'hFFFF_FFF3,   32'h0,         32'h0000_0080, 1, 0));
      vecs.push_back(mk(0, F_HU, 32'hFFFF_FFF2,   32'h0,         32'h0000_80FF, 1, 0));
      vecs.push_back(mk(0, F_H,  32'hFFFF_FFF2,   32'h0,         32'hFFFF_80FF, 1, 0));
      vecs.push_back(mk(0, F_H,  A_DUTY,          32'h0,         32'h0000_4010, 1, 0));
      vecs.push_back(mk(0, F_B,  A_DUTY,          32'h0,         32'h0000_0010, 1, 0));
      vecs.push_back(mk(1, F_W,  32'hFFFF_FFF2,   32'h1234_5678, 32'h0000_0000, 1, 0));
      vecs.push_back(mk(0, F_W,  A_DUTY,          32'h0,         32'h80FF_4010, 1, 0));
      vecs.push_back(mk(1, F_W,  A_US,            32'hFFFF_FFFF, 32'h0,         1, 1));
      vecs.push_back(mk(0, F_W,  A_US,            32'h0,         32'h0,         1, 1));
      vecs.push_back(mk(0, F_H,  32'hFFFF_FFF1,   32'h0,         32'h0000_0000, 1, 0));
      vecs.push_back(mk(0, F_W,  32'hFFFF_FFF3,   32'h0,         32'h0000_0000, 1, 0));
      vecs.push_back(mk(1, F_W,  32'hFFFF_FFFC,   32'hA5A5_A5A5, 32'h0000_0000, 1, 0));
      vecs.push_back(mk(0, F_W,  32'hFFFF_FFFC,   32'h0,         32'h0000_0000, 1, 0));
      vecs.push_back(mk(0, F_W,  32'h0000_2000,   32'h0,         32'h0000_0000, 0, 0));
      vecs.push_back(mk(1, F_W,  32'h0000_2000,   32'h0,         32'h0000_0000, 0, 0));
      vecs.push_back(mk(1, F_W,  32'hFFFF_FFE0,   32'h0,         32'h0000_0000, 0, 0));
      vecs.push_back(mk(1, F_W,  32'h7FFF_FFF0,   32'h0,         32'h0000_0000, 0, 0));
      vecs.push_back(mk(0, F_W,  A_DUTY,          32'h0,         32'h80FF_4010, 1, 0));
      vecs.push_back(mk(1, F_B,  32'hFFFF_FFF2,   32'h1122_33AB, 32'hFFFF_FFFF, 1, 0));
      vecs.push_back(mk(0, F_W,  A_DUTY,          32'h0,         32'h80AB_4010, 1, 0));
      vecs.push_back(mk(1, F_H,  32'hFFFF_FFF2,   32'hCAFE_1234, 32'hFFFF_80AB, 1, 0));
      vecs.push_back(mk(0, F_W,  A_DUTY,          32'h0,         32'h1234_4010, 1, 0));
      vecs.push_back(mk(1, F_H,  32'hFFFF_FFF1,   32'h0000_5555, 32'h0000_0000, 1, 0));
      vecs.push_back(mk(1, F_BU, A_DUTY,          32'h0000_00EE, 32'h0000_0010, 1, 0));
      vecs.push_back(mk(1, F_HU, 32'hFFFF_FFF2,   32'h0000_FFFF, 32'h0000_1234, 1, 0));
      vecs.push_back(mk(1, 3'b011, A_DUTY,        32'h0,         32'h1234_4010, 1, 0));
      vecs.push_back(mk(0, F_W,  A_DUTY,          32'h0,         32'h1234_4010, 1, 0));
      vecs.push_back(mk(0, 3'b110, A_DUTY,        32'h0,         32'h1234_4010, 1, 0));
      vecs.push_back(mk(0, 3'b111, 32'hFFFF_FFF2, 32'h0,         32'h0000_0000, 1, 0));
      vecs.push_back(mk(0, F_W,  A_MS,            32'h0,         32'h0000_0001, 1, 0));
      vecs.push_back(mk(1, F_W,  A_MS,            32'h0,         32'h0000_0001, 1, 0));
      vecs.push_back(mk(0, F_W,  A_MS,            32'h0,         32'h0000_0001, 1, 0));
      vecs.push_back(mk(1, F_B,  32'hFFFF_FFF3,   32'h7788_99C3, 32'h0000_0012, 1, 0));
      vecs.push_back(mk(0, F_BU, 32'hFFFF_FFF3,   32'h0,         32'h0000_00C3, 1, 0));
      vecs.push_back(mk(0, F_B,  32'hFFFF_FFF3,   32'h0,         32'hFFFF_FFC3, 1, 0));
      vecs.push_back(mk(1, F_W,  A_DUTY,          32'hDEAD_BEEF, 32'hC334_4010, 1, 0));
      vecs.push_back(mk(0, F_W,  A_DUTY,          32'h0,         32'hDEAD_BEEF, 1, 0));
      vecs.push_back(mk(0, F_HU, A_DUTY,          32'h0,         32'h0000_BEEF, 1, 0));
      vecs.push_back(mk(0, F_H,  32'hFFFF_FFF2,   32'h0,         32'hFFFF_DEAD, 1, 0));
      vecs.push_back(mk(1, F_W,  A_DUTY,          32'h0,         32'hDEAD_BEEF, 1, 0));
      vecs.push_back(mk(0, F_W,  A_DUTY,          32'h0,         32'h0000_0000, 1, 0));

      // Reset state
      reset = 1'b0;
      drive(0, F_W, A_DUTY, 32'h0);
      repeat (3) step();
      chk32("reset data", dmem_data_out, 32'h0);
      chk32("reset hit", 32'(hit), 32'h0);
      chk32("reset pwm", 32'({blue, green, red, led}), 32'h0);

      // First microsecond tick at edge 12 after release
      reset = 1'b1;
      cyc   = 0;
      drive(0, F_W, A_US, 32'h0);
      repeat (12) step();
      chk32("micros before tick", dmem_data_out, 32'h0);
      chk32("micros hit", 32'(hit), 32'h1);
      step();
      chk32("micros first tick", dmem_data_out, 32'h1);

      // First millisecond increment at edge 12000
      drive(0, F_W, A_MS, 32'h0);
      while (cyc < 12000) step();
      chk32("millis before 12000", dmem_data_out, 32'h0);
      step();
      chk32("millis at 12000", dmem_data_out, 32'h1);
      drive(0, F_W, A_US, 32'h0);
      step();
      chk32("micros at 12002", dmem_data_out, us_model());

      // Directed bus vectors
      foreach (vecs[i]) begin
         drive(vecs[i].wren, vecs[i].f3, vecs[i].addr, vecs[i].wdata);
         step();
         chk32($sformatf("vec%0d data", i), dmem_data_out,
               vecs[i].use_us ? us_model() : vecs[i].exp_data);
         chk32($sformatf("vec%0d hit", i), 32'(hit), 32'(vecs[i].exp_hit));
      end

      // PWM: duty 0, then 0x40 written mid-period
      drive(0, F_W, A_DUTY, 32'h0);
      wait_cnt(255, 4'b0000, 1'b0, "settle");
      run_period("duty0", 32'h0);
      wait_cnt(100, 4'b0000, 1'b1, "idle to 100");
      drive(1, F_W, A_DUTY, 32'h0000_0040);
      step();
      drive(0, F_W, A_DUTY, 32'h0);
      step();
      chk32("duty readback 40", dmem_data_out, 32'h0000_0040);
      wait_cnt(255, 4'b0000, 1'b1, "pwm40 hold");
      run_period("pwm40 p1", 32'h0000_0040);
      run_period("pwm40 p2", 32'h0000_0040);

      // Store at the boundary edge: shadow takes the pre-store duty
      drive(1, F_W, A_DUTY, 32'hFFFF_FFFF);
      run_period("boundary store", 32'h0000_0040);
      drive(0, F_W, A_DUTY, 32'h0);
      run_period("pwmFF", 32'hFFFF_FFFF);

      // Reset mid-period at pwm_cnt=100
      wait_cnt(100, 4'b1111, 1'b1, "pwmFF to 100");
      reset = 1'b0;
      step();
      chk32("midreset pwm", 32'({blue, green, red, led}), 32'h0);
      chk32("midreset hit", 32'(hit), 32'h0);
      chk32("midreset data", dmem_data_out, 32'h0);
      reset = 1'b1;
      cyc   = 0;
      step();
      chk32("duty after reset", dmem_data_out, 32'h0);

      // After reset: outputs stay low, timebase restarts
      drive(0, F_W, A_US, 32'h0);
      bad_out = 0;
      bad_us  = 0;
      for (int n = 0; n < 300; n++) begin
         step();
         if ({blue, green, red, led} !== 4'b0000) bad_out++;
         if (dmem_data_out !== us_model()) bad_us++;
         if (cyc == 13) chk32("tick after reset", dmem_data_out, 32'h1);
      end
      chk32("post-reset pwm low", 32'(bad_out), 32'h0);
      chk32("post-reset micros", 32'(bad_us), 32'h0);

      // MICROS wrap
      dut.r_micros = 32'hFFFF_FFFF;
      dut.r_us_pre = 4'(US_DIV - 1);
      step();
      chk32("wrap pre", dmem_data_out, 32'hFFFF_FFFF);
      step();
      chk32("wrap to zero", dmem_data_out, 32'h0);
      step();
      chk32("wrap hold", dmem_data_out, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
